// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: registered instruction memory with valid/ready fetch port, program-load port
// and a post-reset clear sweep that fills every entry with INIT_WORD.
module instr_mem_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 64,
  parameter int BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = 'h13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_en,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ridx, pidx;
  logic rerr, perr, accept;
  assign ridx = BYTE_ADDR != 0 ? req_addr >> 2 : req_addr;
  assign pidx = BYTE_ADDR != 0 ? prog_addr >> 2 : prog_addr;
  assign rerr = ridx >= ADDR_W'(DEPTH) || (BYTE_ADDR != 0 && req_addr[1:0] != 2'b00);
  assign perr = pidx >= ADDR_W'(DEPTH) || (BYTE_ADDR != 0 && prog_addr[1:0] != 2'b00);
  assign accept = req_valid && req_ready;
  always_comb begin
    state_nx = (state == CLEAR && clr_cnt == IW'(DEPTH - 1)) ? RUN : state;
    busy = state == CLEAR;
    prog_ready = state == RUN;
    req_ready = state == RUN && !prog_en && (!rsp_valid || rsp_ready);
  end
  // The array has no reset; the sweep provides its defined contents.
  always_ff @(posedge clk) begin
    if (busy)
      mem[clr_cnt] <= INIT_WORD;
    else if (prog_en && !perr)
      mem[pidx[IW-1:0]] <= prog_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= INIT_WORD;
    end else begin
      state <= state_nx;
      clr_cnt <= busy ? clr_cnt + 1'b1 : '0;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_err <= rerr;
        rsp_data <= rerr ? INIT_WORD : mem[ridx[IW-1:0]];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
